// File: rtl/tausworthe_pkg.sv
// Shared types and helpers for the Tausworthe 3-component URNG generator and checker.
// Latency: n/a (package of pure functions and types).
// Backpressure: n/a.
package tausworthe_pkg;

    typedef logic [31:0] dat_t;

    // Three-component generator state.
    typedef struct packed {
        dat_t s0;
        dat_t s1;
        dat_t s2;
    } taus_state_t;

    // Checker hunt/lock state.
    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } chk_state_t;

    // Each component needs a minimum seed value or it degenerates to a fixed point;
    // low seeds are lifted by the same offset the generator uses so both sides agree.
    function automatic dat_t get_seed(input dat_t seed, input logic [1:0] id);
        dat_t res;
        case (id)
            2'd0:    res = (seed < 32'd2)  ? seed + 32'd2  : seed;
            2'd1:    res = (seed < 32'd8)  ? seed + 32'd8  : seed;
            default: res = (seed < 32'd16) ? seed + 32'd16 : seed;
        endcase
        return res;
    endfunction

    // One step of all three component recurrences.
    function automatic taus_state_t taus_step(input dat_t s0, input dat_t s1, input dat_t s2);
        taus_state_t nxt;
        nxt.s0 = ((s0 & 32'hFFFF_FFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19);
        nxt.s1 = ((s1 & 32'hFFFF_FFF8) <<  4) ^ (((s1 <<  2) ^ s1) >> 25);
        nxt.s2 = ((s2 & 32'hFFFF_FFF0) << 17) ^ (((s2 <<  3) ^ s2) >> 11);
        return nxt;
    endfunction

endpackage

// File: rtl/tausworthe_ref_gen.sv
// Local reference copy of the URNG: holds state, reloads seeds or steps on request.
// Latency: oexp is combinational from state; load/advance take effect next enabled edge.
// Backpressure: none; state simply holds when neither iload nor iadvance is set.
module tausworthe_ref_gen
    import tausworthe_pkg::*;
#(
    parameter dat_t pSEED0 = '0,
    parameter dat_t pSEED1 = pSEED0,
    parameter dat_t pSEED2 = pSEED1
) (
    input  logic iclk,
    input  logic ireset_n,
    input  logic iclkena,
    input  logic iload,
    input  logic iadvance,
    output dat_t oexp
);

    localparam dat_t SEED0 = get_seed(pSEED0, 2'd0);
    localparam dat_t SEED1 = get_seed(pSEED1, 2'd1);
    localparam dat_t SEED2 = get_seed(pSEED2, 2'd2);

    taus_state_t state_q;
    taus_state_t state_d;

    // Next state: reload wins over advance so a lock loss restarts at E_0.
    always_comb begin
        state_d = state_q;
        if (iload) begin
            state_d.s0 = SEED0;
            state_d.s1 = SEED1;
            state_d.s2 = SEED2;
        end else if (iadvance) begin
            state_d = taus_step(state_q.s0, state_q.s1, state_q.s2);
        end
    end

    // State register, frozen while the clock enable is low.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q.s0 <= SEED0;
            state_q.s1 <= SEED1;
            state_q.s2 <= SEED2;
        end else if (iclkena) begin
            state_q <= state_d;
        end
    end

    assign oexp = state_q.s0 ^ state_q.s1 ^ state_q.s2;

endmodule

// File: rtl/tausworthe_urng_checker.sv
// Receive-side URNG checker: hunts for E_0, then compares every word and counts words/errors.
// Latency: 1 cycle from accepted ival to olock/oerr/counter update.
// Backpressure: none; accepts a word every cycle, iclkena low freezes everything.
module tausworthe_urng_checker
    import tausworthe_pkg::*;
#(
    parameter dat_t        pSEED0    = '0,
    parameter dat_t        pSEED1    = pSEED0,
    parameter dat_t        pSEED2    = pSEED1,
    parameter int unsigned pLOSS_THR = 4,
    parameter int unsigned pCNT_W    = 32
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              iclkena,
    input  logic              ienable,
    input  logic              ival,
    input  dat_t              idat,
    output logic              olock,
    output logic              oerr,
    output logic [pCNT_W-1:0] oword_cnt,
    output logic [pCNT_W-1:0] oerr_cnt
);

    localparam int unsigned       MISS_W   = $clog2(pLOSS_THR + 1);
    localparam logic [MISS_W-1:0] LOSS_THR = MISS_W'(pLOSS_THR);
    localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);
    localparam logic [pCNT_W-1:0] CNT_ONE  = pCNT_W'(1);

    chk_state_t        state_q, state_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [pCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [pCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic              err_q, err_d;

    logic              gen_load;
    logic              gen_adv;
    dat_t              gen_exp;
    logic              match;
    logic [MISS_W-1:0] miss_inc;
    logic [pCNT_W-1:0] word_cnt_inc;
    logic [pCNT_W-1:0] err_cnt_inc;

    tausworthe_ref_gen #(
        .pSEED0 (pSEED0),
        .pSEED1 (pSEED1),
        .pSEED2 (pSEED2)
    ) u_ref_gen (
        .iclk     (iclk),
        .ireset_n (ireset_n),
        .iclkena  (iclkena),
        .iload    (gen_load),
        .iadvance (gen_adv),
        .oexp     (gen_exp)
    );

    assign match    = (idat == gen_exp);
    assign miss_inc = miss_q + MISS_ONE;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign word_cnt_inc = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + CNT_ONE;
    assign err_cnt_inc  = (err_cnt_q  == '1) ? err_cnt_q  : err_cnt_q  + CNT_ONE;

    // Hunt/lock decision, miss tracking and counter updates for the current word.
    always_comb begin
        state_d    = state_q;
        miss_d     = miss_q;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_d      = 1'b0;
        gen_load   = 1'b0;
        gen_adv    = 1'b0;

        if (!ienable) begin
            state_d    = HUNT;
            miss_d     = '0;
            word_cnt_d = '0;
            err_cnt_d  = '0;
            gen_load   = 1'b1;
        end else if (ival) begin
            case (state_q)
                HUNT: begin
                    // Only the sequence start can acquire lock; anything else is ignored.
                    if (match) begin
                        state_d    = LOCK;
                        gen_adv    = 1'b1;
                        word_cnt_d = word_cnt_inc;
                    end
                end
                LOCK: begin
                    // Locked: every word consumes one generator step, good or bad.
                    gen_adv    = 1'b1;
                    word_cnt_d = word_cnt_inc;
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = err_cnt_inc;
                        if (miss_inc == LOSS_THR) begin
                            // Too many consecutive misses: restart the hunt from E_0.
                            state_d  = HUNT;
                            miss_d   = '0;
                            gen_load = 1'b1;
                            gen_adv  = 1'b0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // FSM and output registers, frozen while the clock enable is low.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q    <= HUNT;
            miss_q     <= '0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else if (iclkena) begin
            state_q    <= state_d;
            miss_q     <= miss_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_q      <= err_d;
        end
    end

    assign olock     = (state_q == LOCK);
    assign oerr      = err_q;
    assign oword_cnt = word_cnt_q;
    assign oerr_cnt  = err_cnt_q;

endmodule

// File: tb/tb_tausworthe_urng_checker.sv
// Bench for tausworthe_urng_checker: table vectors, random streams and corner sequences
// against a sequence-index model; a second instance with 4-bit counters covers saturation.
module tb_tausworthe_urng_checker;

    localparam int  NEV  = 2048;
    localparam int  THR  = 4;
    localparam longint MAXA = 64'hFFFF_FFFF;
    localparam longint MAXB = 15;

    logic        iclk = 1'b0;
    logic        ireset_n;
    logic        iclkena;
    logic        ienable;
    logic        ival;
    logic [31:0] idat;

    logic        a_lock, a_err;
    logic [31:0] a_wc, a_ec;
    logic        b_lock, b_err;
    logic [3:0]  b_wc, b_ec;

    always #5 iclk = ~iclk;

    tausworthe_urng_checker dut_a (
        .iclk      (iclk),
        .ireset_n  (ireset_n),
        .iclkena   (iclkena),
        .ienable   (ienable),
        .ival      (ival),
        .idat      (idat),
        .olock     (a_lock),
        .oerr      (a_err),
        .oword_cnt (a_wc),
        .oerr_cnt  (a_ec)
    );

    tausworthe_urng_checker #(.pCNT_W(4)) dut_b (
        .iclk      (iclk),
        .ireset_n  (ireset_n),
        .iclkena   (iclkena),
        .ienable   (ienable),
        .ival      (ival),
        .idat      (idat),
        .olock     (b_lock),
        .oerr      (b_err),
        .oword_cnt (b_wc),
        .oerr_cnt  (b_ec)
    );

    // Model: position in the expected sequence plus lock flag and plain integer counts.
    typedef struct {
        bit     lock;
        bit     err;
        int     k;
        int     miss;
        longint wc;
        longint ec;
    } model_t;

    typedef struct {
        bit          val;
        logic [31:0] dat;
        bit          lock;
        bit          err;
        int          wc;
        int          ec;
    } vec_t;

    logic [31:0] ev [NEV];
    model_t      ma, mb;
    vec_t        tbl [6];
    int          errors = 0;
    int          checks = 0;

    function automatic model_t mreset();
        model_t m;
        m.lock = 1'b0; m.err = 1'b0; m.k = 0; m.miss = 0; m.wc = 0; m.ec = 0;
        return m;
    endfunction

    function automatic longint sat(longint v, longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic model_t mstep(model_t m_in, bit rst, bit ena, bit en, bit val,
                                     logic [31:0] d, longint maxv);
        model_t m;
        m = m_in;
        if (rst || (ena && !en)) return mreset();
        if (!ena) return m;
        m.err = 1'b0;
        if (val) begin
            if (!m.lock) begin
                if (d == ev[m.k]) begin
                    m.lock = 1'b1;
                    m.k    = m.k + 1;
                    m.wc   = sat(m.wc + 1, maxv);
                end
            end else begin
                m.wc = sat(m.wc + 1, maxv);
                if (d == ev[m.k]) begin
                    m.miss = 0;
                end else begin
                    m.err  = 1'b1;
                    m.ec   = sat(m.ec + 1, maxv);
                    m.miss = m.miss + 1;
                end
                m.k = m.k + 1;
                if (m.miss == THR) begin
                    m.lock = 1'b0;
                    m.k    = 0;
                    m.miss = 0;
                end
            end
        end
        return m;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " a.lock"}, longint'(a_lock), longint'(ma.lock));
        chk({tag, " a.err"},  longint'(a_err),  longint'(ma.err));
        chk({tag, " a.wc"},   longint'(a_wc),   ma.wc);
        chk({tag, " a.ec"},   longint'(a_ec),   ma.ec);
        chk({tag, " b.lock"}, longint'(b_lock), longint'(mb.lock));
        chk({tag, " b.err"},  longint'(b_err),  longint'(mb.err));
        chk({tag, " b.wc"},   longint'(b_wc),   mb.wc);
        chk({tag, " b.ec"},   longint'(b_ec),   mb.ec);
    endtask

    // One clock: drive inputs, step the models at the edge, compare 1 time unit later.
    task automatic cyc(input string tag, input bit val, input logic [31:0] d);
        ival = val;
        idat = d;
        @(posedge iclk);
        ma = mstep(ma, !ireset_n, iclkena, ienable, val, d, MAXA);
        mb = mstep(mb, !ireset_n, iclkena, ienable, val, d, MAXB);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] s0, s1, s2, d;
        int          pulses, drops;
        longint      snap_wc, snap_ec;
        bit          snap_err;

        // Expected sequence from seeds 0 lifted to 2, 8, 16.
        s0 = 32'd2; s1 = 32'd8; s2 = 32'd16;
        for (int i = 0; i < NEV; i++) begin
            ev[i] = s0 ^ s1 ^ s2;
            s0 = ((s0 & 32'hFFFF_FFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19);
            s1 = ((s1 & 32'hFFFF_FFF8) <<  4) ^ (((s1 <<  2) ^ s1) >> 25);
            s2 = ((s2 & 32'hFFFF_FFF0) << 17) ^ (((s2 <<  3) ^ s2) >> 11);
        end

        tbl[0] = '{1'b1, 32'h0000_001A,         1'b1, 1'b0, 1, 0};
        tbl[1] = '{1'b1, 32'h0020_2080,         1'b1, 1'b0, 2, 0};
        tbl[2] = '{1'b0, 32'h0000_0000,         1'b1, 1'b0, 2, 0};
        tbl[3] = '{1'b1, ev[2] ^ 32'h0000_0001, 1'b1, 1'b1, 3, 1};
        tbl[4] = '{1'b1, ev[3],                 1'b1, 1'b0, 4, 1};
        tbl[5] = '{1'b1, 32'h0000_001A,         1'b1, 1'b1, 5, 2};

        // Reset state.
        ireset_n = 1'b0; iclkena = 1'b1; ienable = 1'b1; ival = 1'b0; idat = '0;
        ma = mreset(); mb = mreset();
        #12;
        check_all("reset");
        @(posedge iclk);
        #1 ireset_n = 1'b1;
        cyc("idle", 1'b0, 32'h0);

        // Known first words, then a mismatch and a recovery while locked.
        for (int i = 0; i < 6; i++) begin
            cyc("tbl", tbl[i].val, tbl[i].dat);
            chk($sformatf("tbl%0d lock", i), longint'(a_lock), longint'(tbl[i].lock));
            chk($sformatf("tbl%0d err", i),  longint'(a_err),  longint'(tbl[i].err));
            chk($sformatf("tbl%0d wc", i),   longint'(a_wc),   longint'(tbl[i].wc));
            chk($sformatf("tbl%0d ec", i),   longint'(a_ec),   longint'(tbl[i].ec));
        end

        // Synchronous restart, then noise in HUNT before the sequence start.
        ienable = 1'b0;
        cyc("restart", 1'b1, ev[0]);
        chk("restart lock", longint'(a_lock), 0);
        chk("restart wc", longint'(a_wc), 0);
        ienable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            if (d == ev[0]) d = d ^ 32'h1;
            cyc("hunt", 1'b1, d);
            chk("hunt lock", longint'(a_lock), 0);
            chk("hunt wc", longint'(a_wc), 0);
        end
        cyc("acquire", 1'b1, ev[0]);
        chk("acquire lock", longint'(a_lock), 1);
        chk("acquire wc", longint'(a_wc), 1);

        // Long stream with random gaps and one flipped bit.
        pulses = 0; drops = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3) == 0) begin
                cyc("gap", 1'b0, $urandom);
                if (a_lock !== 1'b1) drops++;
            end
            d = ev[1 + i];
            if (i == 100) d = d ^ 32'h0000_0020;
            cyc("stream", 1'b1, d);
            if (a_err === 1'b1) pulses++;
            if (a_lock !== 1'b1) drops++;
        end
        chk("stream err pulses", pulses, 1);
        chk("stream lock drops", drops, 0);
        chk("stream ec", longint'(a_ec), 1);
        chk("stream wc", longint'(a_wc), 1001);

        // Clock enable low with valid words present: nothing moves.
        snap_wc = a_wc; snap_ec = a_ec; snap_err = a_err;
        iclkena = 1'b0;
        for (int i = 0; i < 5; i++) cyc("clkena", 1'b1, ev[ma.k] ^ 32'h8000_0000);
        chk("clkena wc", longint'(a_wc), snap_wc);
        chk("clkena ec", longint'(a_ec), snap_ec);
        chk("clkena err", longint'(a_err), longint'(snap_err));
        chk("clkena lock", longint'(a_lock), 1);
        iclkena = 1'b1;

        // Consecutive bad words until lock is lost, then relock from E_0.
        pulses = 0;
        for (int i = 0; i < THR; i++) begin
            cyc("loss", 1'b1, ev[ma.k] ^ 32'hFFFF_0000);
            if (a_err === 1'b1) pulses++;
            if (i < THR - 1) chk("loss lock held", longint'(a_lock), 1);
        end
        chk("loss pulses", pulses, THR);
        chk("loss lock", longint'(a_lock), 0);
        chk("loss ec", longint'(a_ec), 1 + THR);
        cyc("relock e1", 1'b1, ev[1]);
        chk("relock e1 lock", longint'(a_lock), 0);
        cyc("relock e0", 1'b1, ev[0]);
        cyc("relock e1b", 1'b1, ev[1]);
        chk("relock lock", longint'(a_lock), 1);
        chk("relock err", longint'(a_err), 0);

        // Asynchronous reset in the middle of a cycle.
        #2 ireset_n = 1'b0;
        #1;
        chk("async lock", longint'(a_lock), 0);
        chk("async wc", longint'(a_wc), 0);
        chk("async ec", longint'(a_ec), 0);
        ma = mreset(); mb = mreset();
        cyc("in reset", 1'b1, ev[0]);
        ireset_n = 1'b1;
        cyc("rel e0", 1'b1, ev[0]);
        cyc("rel e1", 1'b1, ev[1]);
        chk("rel lock", longint'(a_lock), 1);

        // ienable low while locked: cleared at the next edge.
        ienable = 1'b0;
        chk("ienable pre lock", longint'(a_lock), 1);
        cyc("ienable", 1'b1, ev[2]);
        chk("ienable lock", longint'(a_lock), 0);
        chk("ienable wc", longint'(a_wc), 0);
        ienable = 1'b1;

        // Saturation on the narrow-counter instance.
        cyc("sat e0", 1'b1, ev[0]);
        for (int i = 0; i < 40; i++) begin
            d = ev[mb.k];
            if (i % 2 == 1) d = ~d;
            cyc("sat", 1'b1, d);
        end
        chk("sat b.wc", longint'(b_wc), 15);
        chk("sat b.ec", longint'(b_ec), 15);
        chk("sat b.err", longint'(b_err), 1);
        chk("sat b.lock", longint'(b_lock), 1);
        chk("sat a.wc", longint'(a_wc), 41);
        chk("sat a.ec", longint'(a_ec), 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
